// File: rtl/memoria_programa.sv
// rtl/memoria_programa.sv - loadable instruction memory for the MIPS fetch stage
// Bytes stream in MSB-first during LOAD; fetch reads word-indexed by byte PC in RUN.
module memoria_programa #(
  parameter int               NBITS     = 32,
  parameter int               DEPTH     = 64,
  parameter int               ADDR_W    = $clog2(DEPTH),
  parameter logic [NBITS-1:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_load_start,
  input  logic              i_load_valid,
  input  logic [7:0]        i_load_data,
  input  logic [NBITS-1:0]  i_PC,
  input  logic              i_read_en,
  input  logic              i_flush,
  output logic [NBITS-1:0]  o_Instruction,
  output logic              o_halt,
  output logic              o_addr_error,
  output logic              o_load_busy,
  output logic              o_load_done,
  output logic [ADDR_W:0]   o_prog_words
);

  localparam int               BYTES     = NBITS / 8;
  localparam int               BCW       = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [BCW-1:0]   LAST_BYTE = BCW'(BYTES - 1);
  localparam logic [ADDR_W:0]  DEPTH_W   = (ADDR_W + 1)'(DEPTH);
  localparam logic [NBITS-1:0] PC_LIMIT  = NBITS'(DEPTH) << 2;

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t             state_q, state_d;
  logic [BCW-1:0]     cnt_q, cnt_d;
  logic [NBITS-9:0]   buf_q, buf_d;
  logic [ADDR_W:0]    ptr_q, ptr_d;
  logic               done_q, done_d;
  logic [NBITS-1:0]   instr_q, instr_d;
  logic               halt_q, halt_d;
  logic               aerr_q, aerr_d;

  logic [NBITS-1:0]   mem [DEPTH];
  logic [NBITS-1:0]   word_full;
  logic               wr_en;
  logic [ADDR_W-1:0]  rd_idx;
  logic               bad_addr;

  assign word_full = {buf_q, i_load_data};
  assign rd_idx    = i_PC[ADDR_W+1:2];
  // Full-width compare so high PC bits can never alias onto a valid index.
  assign bad_addr  = (|i_PC[1:0]) || (i_PC >= PC_LIMIT);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    ptr_d   = ptr_q;
    done_d  = 1'b0;
    wr_en   = 1'b0;
    if (i_load_start) begin
      state_d = LOAD;
      cnt_d   = '0;
      ptr_d   = '0;
    end else if (state_q == LOAD && i_load_valid) begin
      buf_d = word_full[NBITS-9:0];
      if (cnt_q == LAST_BYTE) begin
        wr_en = 1'b1;
        cnt_d = '0;
        ptr_d = ptr_q + 1'b1;
        if (word_full == HALT_WORD || (ptr_q + 1'b1) == DEPTH_W) begin
          state_d = RUN;
          done_d  = 1'b1;
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    instr_d = instr_q;
    halt_d  = halt_q;
    aerr_d  = aerr_q;
    if (i_flush) begin
      instr_d = '0;
      halt_d  = 1'b0;
      aerr_d  = 1'b0;
    end else if (i_read_en) begin
      instr_d = '0;
      halt_d  = 1'b0;
      aerr_d  = 1'b0;
      if (state_q == RUN) begin
        if (bad_addr) begin
          aerr_d = 1'b1;
        end else begin
          instr_d = mem[rd_idx];
          halt_d  = (mem[rd_idx] == HALT_WORD);
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      buf_q   <= '0;
      ptr_q   <= '0;
      done_q  <= 1'b0;
      instr_q <= '0;
      halt_q  <= 1'b0;
      aerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      ptr_q   <= ptr_d;
      done_q  <= done_d;
      instr_q <= instr_d;
      halt_q  <= halt_d;
      aerr_q  <= aerr_d;
    end
  end

  // Program storage is deliberately unreset so a loaded program survives reset.
  always_ff @(posedge i_clk) begin
    if (wr_en) mem[ptr_q[ADDR_W-1:0]] <= word_full;
  end

  assign o_Instruction = instr_q;
  assign o_halt        = halt_q;
  assign o_addr_error  = aerr_q;
  assign o_load_busy   = (state_q == LOAD);
  assign o_load_done   = done_q;
  assign o_prog_words  = ptr_q;

endmodule

// File: tb/tb_memoria_programa.sv
// tb/tb_memoria_programa.sv - directed bench for memoria_programa (DEPTH=64 and DEPTH=4)
module tb_memoria_programa;

  logic clk;
  logic rst_n;

  logic        a_start, a_valid, a_re, a_fl;
  logic [7:0]  a_data;
  logic [31:0] a_pc, a_instr;
  logic        a_halt, a_aerr, a_busy, a_done;
  logic [6:0]  a_words;

  logic        b_start, b_valid, b_re, b_fl;
  logic [7:0]  b_data;
  logic [31:0] b_pc, b_instr;
  logic        b_halt, b_aerr, b_busy, b_done;
  logic [2:0]  b_words;

  int n_chk = 0;
  int n_fail = 0;
  int a_done_cnt = 0;
  int b_done_cnt = 0;
  int base;

  memoria_programa dut_a (
    .i_clk(clk), .i_reset_n(rst_n), .i_load_start(a_start), .i_load_valid(a_valid),
    .i_load_data(a_data), .i_PC(a_pc), .i_read_en(a_re), .i_flush(a_fl),
    .o_Instruction(a_instr), .o_halt(a_halt), .o_addr_error(a_aerr),
    .o_load_busy(a_busy), .o_load_done(a_done), .o_prog_words(a_words)
  );

  memoria_programa #(.DEPTH(4)) dut_b (
    .i_clk(clk), .i_reset_n(rst_n), .i_load_start(b_start), .i_load_valid(b_valid),
    .i_load_data(b_data), .i_PC(b_pc), .i_read_en(b_re), .i_flush(b_fl),
    .o_Instruction(b_instr), .o_halt(b_halt), .o_addr_error(b_aerr),
    .o_load_busy(b_busy), .o_load_done(b_done), .o_prog_words(b_words)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (a_done === 1'b1) a_done_cnt++;
    if (b_done === 1'b1) b_done_cnt++;
  end

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic        re;
    logic        fl;
    logic        care;
    logic [31:0] instr;
    logic        halt;
    logic        aerr;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_a();
    a_start = 1'b1;
    step();
    a_start = 1'b0;
  endtask

  task automatic send_a(input logic [7:0] b);
    a_valid = 1'b1;
    a_data  = b;
    step();
    a_valid = 1'b0;
  endtask

  task automatic send_word_a(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_a(w[8*i +: 8]);
  endtask

  task automatic send_b(input logic [7:0] b);
    b_valid = 1'b1;
    b_data  = b;
    step();
    b_valid = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{"rd_pc0",       32'd0,   1, 0, 1, 32'h2002_0005, 0, 0};
    vecs[1]  = '{"rd_pc4_halt",  32'd4,   1, 0, 1, 32'hFFFF_FFFF, 1, 0};
    vecs[2]  = '{"rd_pc8",       32'd8,   1, 0, 0, 32'h0,         0, 0};
    vecs[3]  = '{"rd_pc4_again", 32'd4,   1, 0, 1, 32'hFFFF_FFFF, 1, 0};
    vecs[4]  = '{"stall_hold",   32'd8,   0, 0, 1, 32'hFFFF_FFFF, 1, 0};
    vecs[5]  = '{"after_stall",  32'd8,   1, 0, 0, 32'h0,         0, 0};
    vecs[6]  = '{"pre_flush",    32'd4,   1, 0, 1, 32'hFFFF_FFFF, 1, 0};
    vecs[7]  = '{"flush_wins",   32'd0,   0, 1, 1, 32'h0,         0, 0};
    vecs[8]  = '{"misalign6",    32'd6,   1, 0, 1, 32'h0,         0, 1};
    vecs[9]  = '{"stall_aerr",   32'd6,   0, 0, 1, 32'h0,         0, 1};
    vecs[10] = '{"flush_clr",    32'd0,   1, 1, 1, 32'h0,         0, 0};
    vecs[11] = '{"pc256",        32'd256, 1, 0, 1, 32'h0,         0, 1};
    vecs[12] = '{"pc_alias",     32'h0100_0000, 1, 0, 1, 32'h0,   0, 1};
    vecs[13] = '{"rd_pc0_b",     32'd0,   1, 0, 1, 32'h2002_0005, 0, 0};
    vecs[14] = '{"last_word",    32'd252, 1, 0, 0, 32'h0,         0, 0};
    vecs[15] = '{"misalign1",    32'd1,   1, 0, 1, 32'h0,         0, 1};

    rst_n = 1'b0;
    a_start = 0; a_valid = 0; a_data = 0; a_pc = 0; a_re = 1; a_fl = 0;
    b_start = 0; b_valid = 0; b_data = 0; b_pc = 0; b_re = 1; b_fl = 0;
    step();
    step();
    chk("rst_instr", a_instr, 32'h0);
    chk("rst_halt", {31'b0, a_halt}, 32'h0);
    chk("rst_aerr", {31'b0, a_aerr}, 32'h0);
    chk("rst_busy", {31'b0, a_busy}, 32'h0);
    chk("rst_done", {31'b0, a_done}, 32'h0);
    chk("rst_words", {25'b0, a_words}, 32'h0);
    rst_n = 1'b1;
    step();

    base = a_done_cnt;
    start_a();
    chk("busy_load", {31'b0, a_busy}, 32'h1);
    chk("idle_nop", a_instr, 32'h0);
    send_word_a(32'h2002_0005);
    chk("words_mid", {25'b0, a_words}, 32'd1);
    chk("busy_mid", {31'b0, a_busy}, 32'h1);
    send_word_a(32'hFFFF_FFFF);
    chk("done_pulse", {31'b0, a_done}, 32'h1);
    chk("busy_end", {31'b0, a_busy}, 32'h0);
    chk("prog_words2", {25'b0, a_words}, 32'd2);
    step();
    chk("done_low", {31'b0, a_done}, 32'h0);
    step();
    chk("done_once", a_done_cnt - base, 32'd1);

    for (int i = 0; i < 16; i++) begin
      a_pc = vecs[i].pc;
      a_re = vecs[i].re;
      a_fl = vecs[i].fl;
      step();
      if (vecs[i].care) begin
        chk({vecs[i].name, "_instr"}, a_instr, vecs[i].instr);
        chk({vecs[i].name, "_halt"}, {31'b0, a_halt}, {31'b0, vecs[i].halt});
      end
      chk({vecs[i].name, "_aerr"}, {31'b0, a_aerr}, {31'b0, vecs[i].aerr});
    end
    a_pc = 0; a_re = 1; a_fl = 0;

    base = b_done_cnt;
    b_start = 1'b1;
    step();
    b_start = 1'b0;
    for (int i = 1; i <= 16; i++) send_b(8'(i));
    chk("fill_words", {29'b0, b_words}, 32'd4);
    chk("fill_busy", {31'b0, b_busy}, 32'h0);
    chk("fill_done", {31'b0, b_done}, 32'h1);
    send_b(8'hEE);
    chk("extra_words", {29'b0, b_words}, 32'd4);
    b_pc = 0;
    step();
    chk("fill_w0", b_instr, 32'h0102_0304);
    b_pc = 12;
    step();
    chk("fill_w3", b_instr, 32'h0D0E_0F10);
    b_pc = 16;
    step();
    chk("fill_oor_instr", b_instr, 32'h0);
    chk("fill_oor_aerr", {31'b0, b_aerr}, 32'h1);
    chk("fill_done_once", b_done_cnt - base, 32'd1);

    start_a();
    for (int i = 0; i < 6; i++) send_a(8'hAA + 8'(i));
    rst_n = 1'b0;
    #1;
    chk("abort_instr", a_instr, 32'h0);
    chk("abort_busy", {31'b0, a_busy}, 32'h0);
    chk("abort_words", {25'b0, a_words}, 32'h0);
    chk("abort_aerr", {31'b0, a_aerr}, 32'h0);
    step();
    rst_n = 1'b1;
    step();

    a_start = 1'b1;
    a_valid = 1'b1;
    a_data  = 8'h99;
    step();
    a_start = 1'b0;
    a_valid = 1'b0;
    send_word_a(32'h1111_1111);
    send_word_a(32'hFFFF_FFFF);
    chk("reload_words", {25'b0, a_words}, 32'd2);
    a_pc = 0;
    step();
    chk("reload_w0", a_instr, 32'h1111_1111);
    chk("reload_w0_halt", {31'b0, a_halt}, 32'h0);
    a_pc = 4;
    step();
    chk("reload_w1", a_instr, 32'hFFFF_FFFF);
    chk("reload_w1_halt", {31'b0, a_halt}, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/memoria_programa.md
# memoria_programa

Parametrised, loadable instruction memory for the MIPS fetch stage, replacing the fixed-content ROM. The debug unit streams the program in one byte at a time (UART-paced). The block assembles those bytes into words and writes them into a word-organised array. After loading, the fetch stage reads it with a byte-addressed PC, using stall and flush controls plus halt and address-error flags.

## Interface
- NBITS, 32: instruction/PC width (multiple of 8)
- DEPTH, 64: number of instruction words stored
- ADDR_W, $clog2(DEPTH): word-index width
- HALT_WORD, 32'hFFFF_FFFF: program-terminating instruction
- i_clk  in  1  single clock, all state on rising edge
- i_reset_n  in  1  asynchronous, active-low reset
- i_load_start  in  1  begin (or restart) program load
- i_load_valid  in  1  i_load_data holds a program byte this cycle
- i_load_data  in  8  program byte, most-significant byte of each word first
- i_PC  in  NBITS  byte address from fetch
- i_read_en  in  1  1 = fetch advances, 0 = stall (output held)
- i_flush  in  1  replace next output with NOP
- o_Instruction  out  NBITS  registered fetched instruction
- o_halt  out  1  o_Instruction equals HALT_WORD
- o_addr_error  out  1  PC misaligned or beyond DEPTH for current output
- o_load_busy  out  1  FSM in LOAD
- o_load_done  out  1  one-cycle pulse on LOAD→RUN
- o_prog_words  out  ADDR_W+1  words written in last load, HALT included

## Operation
- FSM states: IDLE (after reset), LOAD, RUN.
- IDLE → LOAD on i_load_start. RUN → LOAD on i_load_start. LOAD + i_load_start → restart LOAD: byte counter, word pointer and o_prog_words cleared.
- LOAD accepts a byte on every i_load_valid cycle. A 2-bit byte counter shifts bytes into a word buffer, MSB first. On the 4th byte the word is written to memory[ptr] and ptr and o_prog_words increment.
- LOAD → RUN when the completed word equals HALT_WORD (HALT is stored) or when ptr reaches DEPTH. o_load_done pulses in the transition cycle. Bytes outside LOAD are ignored.
- A byte arriving in the same cycle as i_load_start is discarded.
- Fetch, RUN only: word index = i_PC >> 2.
  - i_PC[1:0] != 0, or index >= DEPTH: output NOP (all zeros) with o_addr_error=1.
  - Otherwise: output memory[index] with o_addr_error=0.
- In IDLE and LOAD, the fetch output is NOP with o_addr_error=0.
- Priority per cycle: i_flush > !i_read_en > normal read.
  - Flush: NOP, o_addr_error=0, o_halt=0.
  - Stall: o_Instruction, o_halt and o_addr_error hold.
- o_halt is registered with o_Instruction and is 1 exactly when the registered word equals HALT_WORD.
- The memory array has no reset. Contents survive reset and are overwritten only by a load.

## Timing
- Reset values: o_Instruction=0, o_halt=0, o_addr_error=0, o_load_busy=0, o_load_done=0, o_prog_words=0, state=IDLE, byte counter=0, ptr=0.
- Reset during LOAD aborts the load: the partial word is lost and words already written remain in memory.
- Read latency is 1 cycle: i_PC sampled at edge N appears on o_Instruction after edge N.
- Write latency: a word is written at the edge that accepts its 4th byte and is readable from the next cycle.
- o_load_busy is 1 from the edge after i_load_start until the LOAD→RUN edge.
- Fill boundary: the DEPTH-th word written without HALT ends the load, and o_prog_words = DEPTH.
- Address arithmetic: an index of DEPTH or more is out of range. The upper PC bits are not truncated, so aliasing is impossible.

## Test plan
- Load 0x2002_0005 then 0xFFFF_FFFF (8 bytes), then fetch PC 0, 4, 8 → outputs 0x2002_0005, then 0xFFFF_FFFF with o_halt=1, then 0 (never written after reset, X-safe check skipped); o_prog_words=2; o_load_done pulses once.
- PC=4 with a 1-cycle stall (i_read_en=0 while PC moves to 8) → output holds word[1] for 2 cycles, then word[2].
- i_flush=1 together with i_read_en=0 at PC=0 → next output 0 with o_halt=0 (flush wins).
- PC=6 → NOP with o_addr_error=1. PC=4*DEPTH=256 → NOP with o_addr_error=1.
- DEPTH=4, load 16 bytes without HALT → RUN after the 16th byte, o_prog_words=4, and a 17th byte does not corrupt word 0.
- Assert i_reset_n=0 after 6 bytes → IDLE, all outputs 0. Reload 0x1111_1111 and HALT → word[0]=0x1111_1111 and word[1]=HALT, with the earlier word-0 content overwritten.
